// File: rtl/uart_tx_core.sv
// Serial UART transmitter: parallel word in over valid/ready, one async frame out on tx (LSB first).
// Latency: tx falls on the acceptance edge; frame lasts BIT_CYCLES*(1+DATA_BITS+PARITY_EN+STOP_BITS) cycles.
// Backpressure: tx_ready is low for the whole frame; a held tx_valid is accepted the first cycle tx_ready is high.
module uart_tx_core #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IDX_W      = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);
    localparam logic             ODD_PAR   = (PARITY_ODD != 0);
    localparam logic             HAS_PAR   = (PARITY_EN != 0);

    // A bit period shorter than two clocks cannot be timed by the counter.
    generate
        if (BIT_CYCLES < 2) begin : g_bad_rate
            $error("uart_tx_core: CLK_FREQ/BAUD_RATE must be at least 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
            $error("uart_tx_core: DATA_BITS must be 5..9");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx_core: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 bit_end;

    // Next-state logic; line outputs are derived from the next state so they are registered with it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;
        bit_end = (cnt_q == CNT_LAST);

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (tx_valid && ready_q) begin
                    shift_d = tx_data;
                    par_d   = (^tx_data) ^ ODD_PAR;
                    idx_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        stop_d  = 1'b0;
                        state_d = HAS_PAR ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    stop_d  = 1'b0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (stop_q == STOP_LAST) begin
                        stop_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    // State and registered outputs; reset abandons any frame in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: four instances (8N1, 8E1, 8O1, 7N2) at 10 clocks per bit.
// Each cycle every output is compared against a frame-level reference model.
// Directed words first, then randomized valid/data traffic.
module tb_uart_tx_core;

    localparam int N  = 4;
    localparam int BC = 10;

    int dbits [N] = '{8, 8, 8, 7};
    int pen   [N] = '{0, 1, 1, 0};
    int podd  [N] = '{0, 0, 1, 0};
    int sbits [N] = '{1, 1, 1, 2};
    int flen_c[N] = '{100, 110, 110, 100};
    int dir_dn[N] = '{4, 3, 1, 1};

    logic clk = 1'b0;
    logic [N-1:0]      rst;
    logic [N-1:0]      vld = '0;
    logic [N-1:0][7:0] dat = '0;
    logic [N-1:0]      rdy, txl, busy, done;

    always #5 clk = ~clk;

    uart_tx_core #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                   .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst[0]), .tx_data(dat[0]), .tx_valid(vld[0]),
        .tx_ready(rdy[0]), .tx(txl[0]), .tx_busy(busy[0]), .tx_done(done[0]));
    uart_tx_core #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                   .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst[1]), .tx_data(dat[1]), .tx_valid(vld[1]),
        .tx_ready(rdy[1]), .tx(txl[1]), .tx_busy(busy[1]), .tx_done(done[1]));
    uart_tx_core #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                   .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst[2]), .tx_data(dat[2]), .tx_valid(vld[2]),
        .tx_ready(rdy[2]), .tx(txl[2]), .tx_busy(busy[2]), .tx_done(done[2]));
    uart_tx_core #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
                   .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rst(rst[3]), .tx_data(dat[3][6:0]), .tx_valid(vld[3]),
        .tx_ready(rdy[3]), .tx(txl[3]), .tx_busy(busy[3]), .tx_done(done[3]));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: a frame is a list of line levels, one per bit period.
    bit   fb[N][12];
    int   flen[N];
    int   m_t[N];
    bit   m_rdy[N], m_busy[N], m_tx[N], m_done[N];
    bit   acc_now[N];
    int   acc_cyc[N][$];
    int   m_dn[N], dut_dn[N];

    // Stimulus state
    logic [7:0] pend[N][$];
    bit   drove_pend[N];
    bit   go      = 1'b0;
    bit   rand_on = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic build_frame(input int i, input logic [7:0] w);
        int n;
        logic [7:0] mask;
        mask = 8'((1 << dbits[i]) - 1);
        fb[i][0] = 1'b0;
        n = 1;
        for (int b = 0; b < dbits[i]; b++) begin
            fb[i][n] = w[b];
            n++;
        end
        if (pen[i] != 0) begin
            fb[i][n] = (($countones(w & mask) % 2) == 1) ^ (podd[i] != 0);
            n++;
        end
        for (int s = 0; s < sbits[i]; s++) begin
            fb[i][n] = 1'b1;
            n++;
        end
        flen[i] = n * BC;
    endtask

    function automatic bit all_idle();
        bit r;
        r = 1'b1;
        for (int i = 0; i < N; i++)
            if (pend[i].size() != 0 || m_busy[i]) r = 1'b0;
        return r;
    endfunction

    // Model update at each rising edge, then compare every DUT output just after it.
    initial begin
        for (int i = 0; i < N; i++) begin
            m_t[i] = -1; m_rdy[i] = 0; m_busy[i] = 0; m_tx[i] = 1; m_done[i] = 0;
            m_dn[i] = 0; dut_dn[i] = 0; acc_now[i] = 0; flen[i] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < N; i++) begin
                acc_now[i] = 1'b0;
                m_done[i]  = 1'b0;
                if (rst[i]) begin
                    m_t[i] = -1; m_rdy[i] = 0; m_busy[i] = 0; m_tx[i] = 1;
                end else if (m_t[i] >= 0) begin
                    m_t[i]++;
                    if (m_t[i] == flen[i]) begin
                        m_t[i] = -1; m_done[i] = 1; m_rdy[i] = 1; m_busy[i] = 0; m_tx[i] = 1;
                        m_dn[i]++;
                    end else begin
                        m_tx[i] = fb[i][m_t[i] / BC];
                    end
                end else if (m_rdy[i] && vld[i]) begin
                    build_frame(i, dat[i]);
                    m_t[i] = 0; m_tx[i] = fb[i][0]; m_busy[i] = 1; m_rdy[i] = 0;
                    acc_now[i] = 1'b1;
                    acc_cyc[i].push_back(cyc);
                end else begin
                    m_rdy[i] = 1'b1;
                end
            end
            #1;
            for (int i = 0; i < N; i++) begin
                check($sformatf("tx%0d", i),    {31'b0, txl[i]},  {31'b0, m_tx[i]});
                check($sformatf("ready%0d", i), {31'b0, rdy[i]},  {31'b0, m_rdy[i]});
                check($sformatf("busy%0d", i),  {31'b0, busy[i]}, {31'b0, m_busy[i]});
                check($sformatf("done%0d", i),  {31'b0, done[i]}, {31'b0, m_done[i]});
                if (done[i] === 1'b1) begin
                    dut_dn[i]++;
                    if (acc_cyc[i].size() > 0)
                        check($sformatf("frame_len%0d", i), 32'(cyc - acc_cyc[i][$]), 32'(flen_c[i]));
                end
            end
        end
    end

    // Input driver: queued words are held valid until accepted; otherwise random traffic when enabled.
    initial begin
        for (int i = 0; i < N; i++) drove_pend[i] = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (drove_pend[i] && acc_now[i]) void'(pend[i].pop_front());
                drove_pend[i] = 1'b0;
                if (!go) begin
                    vld[i] = (i == 3) ? rst[3] : 1'b0;
                    dat[i] = 8'h41;
                end else if (pend[i].size() > 0) begin
                    vld[i] = 1'b1;
                    dat[i] = pend[i][0];
                    drove_pend[i] = 1'b1;
                end else begin
                    vld[i] = rand_on && ($urandom_range(0, 3) == 0);
                    dat[i] = 8'($urandom);
                end
            end
        end
    end

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(posedge clk);
            #2;
            ok = all_idle();
        end
        check("idle_reached", {31'b0, ok}, 32'd1);
    endtask

    initial begin
        int ca;
        bit seen;
        rst = '1;
        repeat (3) @(negedge clk);
        rst = '0;
        go  = 1'b1;
        repeat (20) @(posedge clk);

        // One frame per configuration: 0x55 8N1, 0xA7 even/odd parity, 0x41 7N2.
        #2;
        pend[0].push_back(8'h55);
        pend[1].push_back(8'hA7);
        pend[2].push_back(8'hA7);
        pend[3].push_back(8'h41);
        wait_idle(400);

        // Back-to-back with valid held, and data changing while a frame is in flight.
        pend[0].push_back(8'h00);
        pend[0].push_back(8'hFF);
        pend[1].push_back(8'h3C);
        pend[1].push_back(8'hFF);
        wait_idle(600);
        check("acc_n0", 32'(acc_cyc[0].size()), 32'd3);
        check("acc_n1", 32'(acc_cyc[1].size()), 32'd3);
        if (acc_cyc[0].size() >= 3)
            check("b2b_gap0", 32'(acc_cyc[0][2] - acc_cyc[0][1]), 32'd101);
        if (acc_cyc[1].size() >= 3)
            check("b2b_gap1", 32'(acc_cyc[1][2] - acc_cyc[1][1]), 32'd111);

        // Reset during cycle 35 of a frame, then a clean frame.
        pend[0].push_back(8'h96);
        seen = 1'b0;
        ca   = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(posedge clk);
            #2;
            if (acc_now[0]) begin
                seen = 1'b1;
                ca   = cyc;
            end
        end
        check("abort_accept", {31'b0, seen}, 32'd1);
        while (cyc < ca + 34) @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        #1;
        pend[0].push_back(8'h5A);
        wait_idle(400);
        for (int i = 0; i < N; i++)
            check($sformatf("dir_dones%0d", i), 32'(dut_dn[i]), 32'(dir_dn[i]));

        // Randomized traffic on all instances.
        rand_on = 1'b1;
        repeat (4000) @(posedge clk);
        #2;
        rand_on = 1'b0;
        wait_idle(400);
        for (int i = 0; i < N; i++)
            check($sformatf("dones%0d", i), 32'(dut_dn[i]), 32'(m_dn[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
